// File: rtl/ram_arb_pkg.sv
// ram_arb_pkg: shared width helpers and operation encoding for the RAM port arbiter.
package ram_arb_pkg;

  // Request operation encoding carried on req_we
  localparam bit OP_RD = 1'b0;
  localparam bit OP_WR = 1'b1;

  // Address width for a RAM of the given depth (at least one bit)
  function automatic int addr_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  // Client index width for the given number of clients (at least one bit)
  function automatic int id_width(input int num);
    return (num > 1) ? $clog2(num) : 1;
  endfunction

endpackage

// File: rtl/rr_pick2.sv
// rr_pick2: combinational round-robin scan that picks up to two winners.
// conflict[a*NUM_REQ+c] marks client c as unsafe to pair with client a on the other port.
module rr_pick2
  import ram_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  localparam int IW = id_width(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0]         valid,
  input  logic [NUM_REQ*NUM_REQ-1:0] conflict,
  input  logic [IW-1:0]              ptr,
  output logic                       vld_a,
  output logic [IW-1:0]              idx_a,
  output logic                       vld_b,
  output logic [IW-1:0]              idx_b,
  output logic                       hazard
);

  // Scan from ptr upward (wrapping); first valid -> A, next non-conflicting valid -> B
  always_comb begin
    int c;
    int a;
    c      = 0;
    a      = 0;
    vld_a  = 1'b0;
    idx_a  = '0;
    vld_b  = 1'b0;
    idx_b  = '0;
    hazard = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      c = int'(ptr) + k;
      if (c >= NUM_REQ) c = c - NUM_REQ;
      if (valid[c]) begin
        if (!vld_a) begin
          vld_a = 1'b1;
          idx_a = IW'(c);
          a     = c;
        end else if (!vld_b) begin
          if (conflict[a*NUM_REQ+c]) begin
            hazard = 1'b1;
          end else begin
            vld_b = 1'b1;
            idx_b = IW'(c);
          end
        end
      end
    end
  end

endmodule

// File: rtl/ram_port_arbiter.sv
// ram_port_arbiter: shares one dual-port RAM (registered read) between NUM_REQ clients,
// granting up to two requests per cycle and routing read data back to the issuer.
// Optional grant/hazard statistics are built when RAM_ARB_STATS_EN is defined.
module ram_port_arbiter
  import ram_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int DEPTH   = 16,
  parameter int WIDTH   = 16,
  localparam int AW = addr_width(DEPTH),
  localparam int IW = id_width(NUM_REQ)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_REQ-1:0]       req_valid,
  output logic [NUM_REQ-1:0]       req_ready,
  input  logic [NUM_REQ-1:0]       req_we,
  input  logic [NUM_REQ*AW-1:0]    req_addr,
  input  logic [NUM_REQ*WIDTH-1:0] req_wdata,
  output logic [NUM_REQ-1:0]       rsp_valid,
  output logic [WIDTH-1:0]         rsp_rdata,
  output logic [WIDTH-1:0]         rsp_rdata_b,
  output logic [NUM_REQ-1:0]       rsp_valid_b,
  output logic                     w_en_a,
  output logic                     w_en_b,
  output logic [AW-1:0]            addr_a,
  output logic [AW-1:0]            addr_b,
  output logic [WIDTH-1:0]         data_in_a,
  output logic [WIDTH-1:0]         data_in_b,
  input  logic [WIDTH-1:0]         data_out_a,
  input  logic [WIDTH-1:0]         data_out_b
`ifdef RAM_ARB_STATS_EN
  ,
  output logic [31:0]              grant_cnt,
  output logic [15:0]              hazard_cnt
`endif
);

  logic [NUM_REQ*NUM_REQ-1:0] conflict;
  logic                       vld_a, vld_b, hazard;
  logic [IW-1:0]              idx_a, idx_b;
  logic                       gnt_a, gnt_b;
  logic                       we_sel_a, we_sel_b;
  logic [AW-1:0]              addr_sel_a, addr_sel_b;
  logic [WIDTH-1:0]           wdata_sel_a, wdata_sel_b;
  logic [IW-1:0]              rr_ptr_reg, rr_ptr_next, last_idx;
  logic [NUM_REQ-1:0]         owner_a_reg, owner_a_next;
  logic [NUM_REQ-1:0]         owner_b_reg, owner_b_next;

  // Pairwise hazard mask: same address on both ports with at least one write
  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_row
    for (genvar gj = 0; gj < NUM_REQ; gj++) begin : g_col
      assign conflict[gi*NUM_REQ+gj] =
        (req_addr[gi*AW +: AW] == req_addr[gj*AW +: AW]) &&
        ((req_we[gi] == OP_WR) || (req_we[gj] == OP_WR));
    end
  end

  rr_pick2 #(.NUM_REQ(NUM_REQ)) u_pick (
    .valid    (req_valid),
    .conflict (conflict),
    .ptr      (rr_ptr_reg),
    .vld_a    (vld_a),
    .idx_a    (idx_a),
    .vld_b    (vld_b),
    .idx_b    (idx_b),
    .hazard   (hazard)
  );

  // No grant is ever issued while reset is held
  assign gnt_a = rst_n && vld_a;
  assign gnt_b = rst_n && vld_b;

  assign we_sel_a    = req_we[idx_a];
  assign we_sel_b    = req_we[idx_b];
  assign addr_sel_a  = req_addr[int'(idx_a)*AW +: AW];
  assign addr_sel_b  = req_addr[int'(idx_b)*AW +: AW];
  assign wdata_sel_a = req_wdata[int'(idx_a)*WIDTH +: WIDTH];
  assign wdata_sel_b = req_wdata[int'(idx_b)*WIDTH +: WIDTH];

  // An idle port issues a harmless read of address 0 whose data is discarded
  assign w_en_a    = gnt_a && (we_sel_a == OP_WR);
  assign w_en_b    = gnt_b && (we_sel_b == OP_WR);
  assign addr_a    = gnt_a ? addr_sel_a : '0;
  assign addr_b    = gnt_b ? addr_sel_b : '0;
  assign data_in_a = gnt_a ? wdata_sel_a : '0;
  assign data_in_b = gnt_b ? wdata_sel_b : '0;

  // Ready strobes for the granted clients
  always_comb begin
    req_ready = '0;
    if (gnt_a) req_ready[idx_a] = 1'b1;
    if (gnt_b) req_ready[idx_b] = 1'b1;
  end

  // Pointer moves just past the last client granted (B follows A in scan order)
  always_comb begin
    last_idx    = gnt_b ? idx_b : idx_a;
    rr_ptr_next = rr_ptr_reg;
    if (gnt_a) rr_ptr_next = (last_idx == IW'(NUM_REQ - 1)) ? '0 : last_idx + 1'b1;
  end

  // One-hot owner of the read each port returns next cycle
  always_comb begin
    owner_a_next = '0;
    owner_b_next = '0;
    if (gnt_a && (we_sel_a == OP_RD)) owner_a_next[idx_a] = 1'b1;
    if (gnt_b && (we_sel_b == OP_RD)) owner_b_next[idx_b] = 1'b1;
  end

  // Pointer and owner registers; reset drops any in-flight response
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr_reg  <= '0;
      owner_a_reg <= '0;
      owner_b_reg <= '0;
    end else begin
      rr_ptr_reg  <= rr_ptr_next;
      owner_a_reg <= owner_a_next;
      owner_b_reg <= owner_b_next;
    end
  end

  // Return lanes are forced to zero whenever no response is owed
  assign rsp_valid   = owner_a_reg;
  assign rsp_valid_b = owner_b_reg;
  assign rsp_rdata   = (|owner_a_reg) ? data_out_a : '0;
  assign rsp_rdata_b = (|owner_b_reg) ? data_out_b : '0;

`ifdef RAM_ARB_STATS_EN
  logic [31:0] grant_cnt_reg;
  logic [15:0] hazard_cnt_reg;

  // Transfer counter wraps; hazard-cycle counter saturates
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      grant_cnt_reg  <= '0;
      hazard_cnt_reg <= '0;
    end else begin
      grant_cnt_reg <= grant_cnt_reg + 32'(gnt_a) + 32'(gnt_b);
      if (hazard && (hazard_cnt_reg != 16'hFFFF)) hazard_cnt_reg <= hazard_cnt_reg + 16'd1;
    end
  end

  assign grant_cnt  = grant_cnt_reg;
  assign hazard_cnt = hazard_cnt_reg;
`else
  // Hazard flag only feeds the statistics counter
  logic unused_hazard;
  assign unused_hazard = hazard;
`endif

endmodule

// File: tb/tb_ram_port_arbiter.sv
// tb_ram_port_arbiter: randomized and directed checks of ram_port_arbiter against a
// list-scan reference model and a behavioural dual-port RAM. Define RAM_ARB_STATS_EN
// to also check the statistics counters.
module tb_ram_port_arbiter;
  localparam int N  = 4;
  localparam int D  = 16;
  localparam int AW = 4;
  localparam int W  = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [N-1:0]    req_valid, req_ready, req_we, rsp_valid, rsp_valid_b;
  logic [N*AW-1:0] req_addr;
  logic [N*W-1:0]  req_wdata;
  logic [W-1:0]    rsp_rdata, rsp_rdata_b, data_in_a, data_in_b, data_out_a, data_out_b;
  logic            w_en_a, w_en_b;
  logic [AW-1:0]   addr_a, addr_b;
`ifdef RAM_ARB_STATS_EN
  logic [31:0]     grant_cnt;
  logic [15:0]     hazard_cnt;
`endif

  // Client-side view of the requests
  bit            c_valid[N];
  bit            c_we[N];
  logic [AW-1:0] c_addr[N];
  logic [W-1:0]  c_wdata[N];

  always_comb begin
    req_valid = '0;
    req_we    = '0;
    req_addr  = '0;
    req_wdata = '0;
    for (int i = 0; i < N; i++) begin
      req_valid[i]          = c_valid[i];
      req_we[i]             = c_we[i];
      req_addr[i*AW +: AW]  = c_addr[i];
      req_wdata[i*W +: W]   = c_wdata[i];
    end
  end

  ram_port_arbiter #(.NUM_REQ(N), .DEPTH(D), .WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .rsp_rdata_b(rsp_rdata_b), .rsp_valid_b(rsp_valid_b),
    .w_en_a(w_en_a), .w_en_b(w_en_b), .addr_a(addr_a), .addr_b(addr_b),
    .data_in_a(data_in_a), .data_in_b(data_in_b),
    .data_out_a(data_out_a), .data_out_b(data_out_b)
`ifdef RAM_ARB_STATS_EN
    , .grant_cnt(grant_cnt), .hazard_cnt(hazard_cnt)
`endif
  );

  // Behavioural dual-port RAM with registered read, write data passed through
  logic [W-1:0] ram [D];
  always @(posedge clk) begin
    if (w_en_a) ram[addr_a] <= data_in_a;
    if (w_en_b) ram[addr_b] <= data_in_b;
    data_out_a <= w_en_a ? data_in_a : ram[addr_a];
    data_out_b <= w_en_b ? data_in_b : ram[addr_b];
  end

  // Reference model state
  logic [W-1:0] mem_m[D];
  int           ptr_m = 0;
  bit [N-1:0]   exp_ready;
  bit           has_a, has_b, exp_haz;
  int           exp_a, exp_b;
  bit [N-1:0]   exp_rv = '0, exp_rvb = '0;
  logic [W-1:0] exp_rd = '0, exp_rdb = '0;
  logic [31:0]  gcnt_m = '0;
  int           hcnt_m = 0;
  int           checks = 0;
  int           errors = 0;

  function automatic bit any_valid();
    for (int i = 0; i < N; i++) if (c_valid[i]) return 1'b1;
    return 1'b0;
  endfunction

  // Rule-level winner selection: order clients from the pointer, take the first two
  // that may legally share the RAM this cycle
  task automatic model_pick();
    int order[$];
    exp_ready = '0;
    has_a = 0;
    has_b = 0;
    exp_haz = 0;
    exp_a = 0;
    exp_b = 0;
    if (rst_n) begin
      for (int k = 0; k < N; k++) order.push_back((ptr_m + k) % N);
      foreach (order[j]) begin
        int c;
        c = order[j];
        if (c_valid[c]) begin
          if (!has_a) begin
            has_a = 1; exp_a = c;
          end else if (!has_b) begin
            if (c_addr[c] == c_addr[exp_a] && (c_we[c] || c_we[exp_a])) exp_haz = 1;
            else begin has_b = 1; exp_b = c; end
          end
        end
      end
      if (has_a) exp_ready[exp_a] = 1'b1;
      if (has_b) exp_ready[exp_b] = 1'b1;
    end
  endtask

  task automatic eval();
    #1;
    model_pick();
  endtask

  // Clock edge: commit the model's transfers, then retire the granted requests
  task automatic advance();
    @(posedge clk);
    exp_rv  = '0;
    exp_rvb = '0;
    if (!rst_n) begin
      ptr_m = 0; gcnt_m = '0; hcnt_m = 0;
    end else begin
      if (has_a && !c_we[exp_a]) begin exp_rv[exp_a] = 1'b1; exp_rd = mem_m[c_addr[exp_a]]; end
      if (has_b && !c_we[exp_b]) begin exp_rvb[exp_b] = 1'b1; exp_rdb = mem_m[c_addr[exp_b]]; end
      if (has_a && c_we[exp_a]) mem_m[c_addr[exp_a]] = c_wdata[exp_a];
      if (has_b && c_we[exp_b]) mem_m[c_addr[exp_b]] = c_wdata[exp_b];
      if (has_a) ptr_m = ((has_b ? exp_b : exp_a) + 1) % N;
      gcnt_m = gcnt_m + 32'(has_a) + 32'(has_b);
      if (exp_haz && hcnt_m < 65535) hcnt_m++;
      if (has_a) $display("txn t=%0t port A client %0d %s addr %0d", $time, exp_a,
                          c_we[exp_a] ? "WR" : "RD", c_addr[exp_a]);
      if (has_b) $display("txn t=%0t port B client %0d %s addr %0d", $time, exp_b,
                          c_we[exp_b] ? "WR" : "RD", c_addr[exp_b]);
    end
    @(negedge clk);
    if (has_a) c_valid[exp_a] = 0;
    if (has_b) c_valid[exp_b] = 0;
  endtask

  // Run cycles until every pending request has transferred (bounded)
  task automatic drain();
    int n;
    n = 0;
    eval();
    while (any_valid() && n < 50) begin
      advance();
      eval();
      n++;
    end
    checks++;
    if (any_valid()) begin errors++; $display("FAIL drain_timeout: pending after %0d cycles, want none", n); end
  endtask

  task automatic set_req(input int c, input bit we, input int addr, input logic [W-1:0] wd);
    c_valid[c] = 1; c_we[c] = we; c_addr[c] = AW'(addr); c_wdata[c] = wd;
  endtask

  task automatic test_reset();
    for (int i = 0; i < N; i++) set_req(i, 0, i + 8, '0);
    repeat (2) @(negedge clk);
    #1;
    checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL reset_ready: got %b want 0000", req_ready); end
    checks++; if (w_en_a !== 1'b0 || w_en_b !== 1'b0) begin errors++; $display("FAIL reset_wen: got %b%b want 00", w_en_a, w_en_b); end
    checks++; if (rsp_valid !== 4'b0000 || rsp_valid_b !== 4'b0000) begin errors++; $display("FAIL reset_rsp_valid: got %b/%b want 0000/0000", rsp_valid, rsp_valid_b); end
    checks++; if (rsp_rdata !== 16'h0 || rsp_rdata_b !== 16'h0) begin errors++; $display("FAIL reset_rdata: got %h/%h want 0000/0000", rsp_rdata, rsp_rdata_b); end
    rst_n = 1;
    eval();
    checks++; if (req_ready !== 4'b0011) begin errors++; $display("FAIL release_ready: got %b want 0011", req_ready); end
    checks++; if (addr_a !== 4'd8 || addr_b !== 4'd9) begin errors++; $display("FAIL release_ports: got A=%0d B=%0d want A=8 B=9", addr_a, addr_b); end
    drain();
  endtask

  task automatic test_fill();
    for (int a = 0; a < D; a += 2) begin
      set_req(0, 1, a, W'($urandom));
      set_req(1, 1, a + 1, W'($urandom));
      drain();
    end
  endtask

  task automatic test_writes();
    set_req(0, 1, 3, 16'hAAAA);
    set_req(1, 1, 4, 16'h5555);
    eval();
    checks++; if (req_ready !== 4'b0011) begin errors++; $display("FAIL writes_ready: got %b want 0011", req_ready); end
    checks++; if (w_en_a !== 1'b1 || w_en_b !== 1'b1) begin errors++; $display("FAIL writes_wen: got %b%b want 11", w_en_a, w_en_b); end
    advance();
    set_req(2, 0, 3, '0);
    eval();
    checks++; if (req_ready !== 4'b0100) begin errors++; $display("FAIL writes_rd_ready: got %b want 0100", req_ready); end
    advance();
    eval();
    checks++; if (rsp_valid !== 4'b0100) begin errors++; $display("FAIL writes_rsp_valid: got %b want 0100", rsp_valid); end
    checks++; if (rsp_rdata !== 16'hAAAA) begin errors++; $display("FAIL writes_rdata: got %h want aaaa", rsp_rdata); end
  endtask

  task automatic test_hazard();
    logic [W-1:0] wd;
    wd = W'($urandom);
    set_req(0, 1, 7, wd);
    set_req(1, 0, 7, '0);
    eval();
    checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL hazard_ready: got %b want 0001", req_ready); end
    checks++; if (w_en_a !== 1'b1 || w_en_b !== 1'b0 || addr_a !== 4'd7) begin errors++; $display("FAIL hazard_ports: got wen=%b%b addr_a=%0d want wen=10 addr_a=7", w_en_a, w_en_b, addr_a); end
    advance();
    eval();
    checks++; if (req_ready !== 4'b0010) begin errors++; $display("FAIL hazard_retry_ready: got %b want 0010", req_ready); end
`ifdef RAM_ARB_STATS_EN
    checks++; if (hazard_cnt !== 16'd1) begin errors++; $display("FAIL hazard_cnt: got %0d want 1", hazard_cnt); end
`endif
    advance();
    eval();
    checks++; if (rsp_valid !== 4'b0010 || rsp_rdata !== wd) begin errors++; $display("FAIL hazard_rdata: got %b/%h want 0010/%h", rsp_valid, rsp_rdata, wd); end
  endtask

  task automatic test_fairness();
    int cnt[N];
    bit [N-1:0] want;
    for (int i = 0; i < N; i++) cnt[i] = 0;
    set_req(3, 0, 0, '0);
    drain();
    for (int cyc = 0; cyc < 8; cyc++) begin
      for (int i = 0; i < N; i++) if (!c_valid[i]) set_req(i, 0, int'($urandom % D), '0);
      eval();
      if (cyc > 0) for (int i = 0; i < N; i++) cnt[i] += int'(rsp_valid[i]) + int'(rsp_valid_b[i]);
      want = (cyc % 2 == 0) ? 4'b0011 : 4'b1100;
      checks++; if (req_ready !== want) begin errors++; $display("FAIL fair_ready[%0d]: got %b want %b", cyc, req_ready, want); end
      advance();
    end
    for (int i = 0; i < N; i++) c_valid[i] = 0;
    eval();
    for (int i = 0; i < N; i++) cnt[i] += int'(rsp_valid[i]) + int'(rsp_valid_b[i]);
    for (int i = 0; i < N; i++) begin
      checks++; if (cnt[i] != 4) begin errors++; $display("FAIL fair_rsp_count[%0d]: got %0d want 4", i, cnt[i]); end
    end
  endtask

  task automatic test_same_addr();
    set_req(2, 0, 9, '0);
    set_req(3, 0, 9, '0);
    eval();
    checks++; if (req_ready !== 4'b1100 || addr_a !== 4'd9 || addr_b !== 4'd9) begin errors++; $display("FAIL same_ready: got %b A=%0d B=%0d want 1100 A=9 B=9", req_ready, addr_a, addr_b); end
    advance();
    eval();
    checks++; if (rsp_valid !== 4'b0100 || rsp_valid_b !== 4'b1000) begin errors++; $display("FAIL same_valid: got %b/%b want 0100/1000", rsp_valid, rsp_valid_b); end
    checks++; if (rsp_rdata !== mem_m[9] || rsp_rdata_b !== mem_m[9]) begin errors++; $display("FAIL same_rdata: got %h/%h want %h", rsp_rdata, rsp_rdata_b, mem_m[9]); end
  endtask

  task automatic test_random();
    bit want_wa, want_wb;
    for (int cyc = 0; cyc < 300; cyc++) begin
      for (int i = 0; i < N; i++)
        if (!c_valid[i] && ($urandom % 2 == 1)) set_req(i, 1'($urandom % 2), int'($urandom % 4), W'($urandom));
      eval();
      want_wa = has_a && c_we[exp_a];
      want_wb = has_b && c_we[exp_b];
      checks++; if (req_ready !== exp_ready) begin errors++; $display("FAIL rnd_ready[%0d]: got %b want %b", cyc, req_ready, exp_ready); end
      checks++; if (w_en_a !== want_wa || w_en_b !== want_wb) begin errors++; $display("FAIL rnd_wen[%0d]: got %b%b want %b%b", cyc, w_en_a, w_en_b, want_wa, want_wb); end
      checks++; if (rsp_valid !== exp_rv || rsp_valid_b !== exp_rvb) begin errors++; $display("FAIL rnd_rsp_valid[%0d]: got %b/%b want %b/%b", cyc, rsp_valid, rsp_valid_b, exp_rv, exp_rvb); end
      checks++; if (rsp_rdata !== ((exp_rv != 0) ? exp_rd : 16'h0)) begin errors++; $display("FAIL rnd_rdata[%0d]: got %h want %h", cyc, rsp_rdata, (exp_rv != 0) ? exp_rd : 16'h0); end
      checks++; if (rsp_rdata_b !== ((exp_rvb != 0) ? exp_rdb : 16'h0)) begin errors++; $display("FAIL rnd_rdata_b[%0d]: got %h want %h", cyc, rsp_rdata_b, (exp_rvb != 0) ? exp_rdb : 16'h0); end
      advance();
    end
    drain();
`ifdef RAM_ARB_STATS_EN
    checks++; if (grant_cnt !== gcnt_m) begin errors++; $display("FAIL rnd_grant_cnt: got %0d want %0d", grant_cnt, gcnt_m); end
    checks++; if (hazard_cnt !== 16'(hcnt_m)) begin errors++; $display("FAIL rnd_hazard_cnt: got %0d want %0d", hazard_cnt, hcnt_m); end
`endif
  endtask

  task automatic test_midflight_reset();
    set_req(0, 0, 5, '0);
    set_req(1, 0, 6, '0);
    eval();
    advance();
    set_req(2, 0, 10, '0);
    set_req(3, 0, 11, '0);
    eval();
    checks++; if ((rsp_valid | rsp_valid_b) !== 4'b0011) begin errors++; $display("FAIL mid_inflight: got %b want 0011", rsp_valid | rsp_valid_b); end
    #1 rst_n = 0;
    exp_rv = '0; exp_rvb = '0;
    #1;
    checks++; if (req_ready !== 4'b0000 || w_en_a !== 1'b0 || w_en_b !== 1'b0) begin errors++; $display("FAIL mid_reset_ports: got ready=%b wen=%b%b want 0000/00", req_ready, w_en_a, w_en_b); end
    checks++; if (rsp_valid !== 4'b0000 || rsp_valid_b !== 4'b0000 || rsp_rdata !== 16'h0) begin errors++; $display("FAIL mid_reset_rsp: got %b/%b/%h want 0000/0000/0000", rsp_valid, rsp_valid_b, rsp_rdata); end
    repeat (2) begin eval(); advance(); end
    for (int i = 0; i < N; i++) c_valid[i] = 0;
    rst_n = 1;
`ifdef RAM_ARB_STATS_EN
    checks++; if (grant_cnt !== 32'd0 || hazard_cnt !== 16'd0) begin errors++; $display("FAIL mid_reset_stats: got %0d/%0d want 0/0", grant_cnt, hazard_cnt); end
`endif
    for (int k = 0; k < 3; k++) begin
      eval();
      checks++; if (rsp_valid !== 4'b0000 || rsp_valid_b !== 4'b0000) begin errors++; $display("FAIL mid_after_release[%0d]: got %b/%b want 0000/0000", k, rsp_valid, rsp_valid_b); end
      advance();
    end
    for (int a = 0; a < D; a++) begin
      set_req(0, 0, a, '0);
      eval();
      advance();
      eval();
      checks++; if (rsp_valid !== 4'b0001 || rsp_rdata !== mem_m[a]) begin errors++; $display("FAIL readback[%0d]: got %b/%h want 0001/%h", a, rsp_valid, rsp_rdata, mem_m[a]); end
      advance();
    end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_writes();
    test_hazard();
    test_fairness();
    test_same_addr();
    test_random();
    test_midflight_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Hard stop so a stuck run still terminates
  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, want finish before 200us");
    $fatal(1);
  end

endmodule
